// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: RAW load-use/no-forward stall detection, branch flush,
// and a memory-wait FSM that freezes the pipeline and latches a sticky timeout error.
module pipeline_hazard_controller #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,          // asynchronous, active-low
  input  logic             i_fwd_en,
  input  logic             i_id_valid,
  input  logic [3:0]       i_id_src1,
  input  logic [3:0]       i_id_src2,
  input  logic             i_id_two_src,
  input  logic [3:0]       i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_r_en,
  input  logic [3:0]       i_mem_dest,
  input  logic             i_mem_wb_en,
  input  logic             i_mem_req,
  input  logic             i_sram_ready,
  input  logic             i_branch_taken,
  output logic             o_hazard_stall,
  output logic             o_freeze_all,
  output logic             o_flush,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int unsigned WCNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic [WCNT_W-1:0]  w_wait_nxt;
  logic [WCNT_W-1:0]  w_wait_inc;
  logic               w_freeze;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_m1_exe, w_m2_exe, w_m1_mem, w_m2_mem;
  logic w_exe_hit, w_mem_hit, w_raw;
  logic w_freeze_all, w_flush, w_stall;

  // Memory-wait FSM state and wait counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= (w_state_nxt == ST_ERROR);
    end
  end

  // Next-state logic; freeze covers the first unready cycle while still in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_freeze    = 1'b0;
    w_wait_inc  = r_wait_cnt + WCNT_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_wait_nxt = '0;
        if (i_mem_req && !i_sram_ready) begin
          w_state_nxt = ST_WAIT;
          w_freeze    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_sram_ready) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end else begin
          w_freeze   = 1'b1;
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == WCNT_W'(WAIT_TIMEOUT)) begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Source/destination matching; src2 only counts when it is a real operand
  always_comb begin
    w_m1_exe  = (i_exe_dest == i_id_src1);
    w_m2_exe  = i_id_two_src && (i_exe_dest == i_id_src2);
    w_m1_mem  = (i_mem_dest == i_id_src1);
    w_m2_mem  = i_id_two_src && (i_mem_dest == i_id_src2);
    w_exe_hit = w_m1_exe || w_m2_exe;
    w_mem_hit = w_m1_mem || w_m2_mem;
    if (i_fwd_en) begin
      w_raw = i_id_valid && i_exe_wb_en && i_exe_mem_r_en && w_exe_hit;
    end else begin
      w_raw = i_id_valid && ((i_exe_wb_en && w_exe_hit) || (i_mem_wb_en && w_mem_hit));
    end
  end

  // Priority freeze > flush > stall; all forced low while reset is held
  always_comb begin
    w_freeze_all = i_rst && w_freeze;
    w_flush      = i_rst && i_branch_taken && !w_freeze_all;
    w_stall      = i_rst && w_raw && !w_flush && !w_freeze_all;
  end

  // Saturating stall-cycle counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_hazard_stall = w_stall;
  assign o_freeze_all   = w_freeze_all;
  assign o_flush        = w_flush;
  assign o_mem_timeout  = r_mem_timeout;
  assign o_stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (WAIT_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_controller;

  localparam int unsigned WT = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          fwd_en, id_valid, id_two_src;
  logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
  logic          exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic          mem_req, sram_ready, branch_taken;
  logic          hazard_stall, freeze_all, flush, mem_timeout;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_controller #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fwd_en       (fwd_en),
    .i_id_valid     (id_valid),
    .i_id_src1      (id_src1),
    .i_id_src2      (id_src2),
    .i_id_two_src   (id_two_src),
    .i_exe_dest     (exe_dest),
    .i_exe_wb_en    (exe_wb_en),
    .i_exe_mem_r_en (exe_mem_r_en),
    .i_mem_dest     (mem_dest),
    .i_mem_wb_en    (mem_wb_en),
    .i_mem_req      (mem_req),
    .i_sram_ready   (sram_ready),
    .i_branch_taken (branch_taken),
    .o_hazard_stall (hazard_stall),
    .o_freeze_all   (freeze_all),
    .o_flush        (flush),
    .o_mem_timeout  (mem_timeout),
    .o_stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fwd_en = 1'b0; id_valid = 1'b0; id_two_src = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    mem_req = 1'b0; sram_ready = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    fwd_en = 1'b1; id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3;
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    // Every cause active while reset is held
    set_load_use();
    mem_req = 1'b1; branch_taken = 1'b1;
    #12;
    check_eq("rst_stall", hazard_stall, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_freeze", freeze_all, 0);
    check_eq("rst_timeout", mem_timeout, 0);
    check_eq("rst_count", stall_count, 0);
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();

    // Load-use with forwarding
    set_load_use();
    #1;
    check_eq("loaduse_stall", hazard_stall, 1);
    check_eq("loaduse_cnt0", stall_count, 0);
    tick();
    check_eq("loaduse_cnt1", stall_count, 1);
    id_valid = 1'b0;
    #1;
    check_eq("invalid_id", hazard_stall, 0);
    tick();
    check_eq("cnt_hold", stall_count, 1);

    // Non-load producer, forwarding on/off, src2 gating
    clear_inputs();
    fwd_en = 1'b1; id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1;
    check_eq("fwd_nonload", hazard_stall, 0);
    fwd_en = 1'b0;
    #1;
    check_eq("nofwd_exe", hazard_stall, 1);
    id_src1 = 4'd5; id_src2 = 4'd3; id_two_src = 1'b0;
    #1;
    check_eq("src2_unused", hazard_stall, 0);
    id_two_src = 1'b1;
    #1;
    check_eq("src2_used", hazard_stall, 1);
    tick();
    clear_inputs();
    id_valid = 1'b1; id_src1 = 4'd9; mem_dest = 4'd9; mem_wb_en = 1'b1;
    #1;
    check_eq("nofwd_mem", hazard_stall, 1);
    fwd_en = 1'b1;
    #1;
    check_eq("fwd_mem", hazard_stall, 0);
    fwd_en = 1'b0; id_src1 = 4'd0; mem_dest = 4'd0;
    #1;
    check_eq("reg0_match", hazard_stall, 1);
    tick();

    // Branch beats a load-use stall
    clear_inputs();
    set_load_use();
    branch_taken = 1'b1;
    #1;
    check_eq("br_flush", flush, 1);
    check_eq("br_stall", hazard_stall, 0);
    tick();

    // 3-cycle memory wait with a branch held across the freeze
    clear_inputs();
    mem_req = 1'b1; sram_ready = 1'b0; branch_taken = 1'b1;
    #1;
    check_eq("mw_c1_freeze", freeze_all, 1);
    check_eq("mw_c1_flush", flush, 0);
    tick();
    set_load_use();
    #1;
    check_eq("mw_c2_freeze", freeze_all, 1);
    check_eq("mw_c2_stall", hazard_stall, 0);
    tick();
    check_eq("mw_c3_freeze", freeze_all, 1);
    check_eq("mw_c3_flush", flush, 0);
    tick();
    sram_ready = 1'b1;
    #1;
    check_eq("mw_c4_freeze", freeze_all, 0);
    check_eq("mw_c4_flush", flush, 1);
    tick();
    clear_inputs();
    #1;
    check_eq("mw_idle", freeze_all, 0);
    check_eq("mw_no_timeout", mem_timeout, 0);
    tick();

    // Timeout: IDLE edge + WT wait edges reach ERROR
    mem_req = 1'b1; sram_ready = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check_eq("to_pre", mem_timeout, 0);
    check_eq("to_pre_freeze", freeze_all, 1);
    tick();
    check_eq("to_err", mem_timeout, 1);
    mem_req = 1'b0; sram_ready = 1'b1;
    tick();
    tick();
    check_eq("to_sticky", mem_timeout, 1);
    check_eq("to_sticky_frz", freeze_all, 1);
    rst = 1'b0;
    #1;
    check_eq("to_rst_timeout", mem_timeout, 0);
    check_eq("to_rst_freeze", freeze_all, 0);

    // Reset released with an outstanding access re-enters WAIT
    mem_req = 1'b1; sram_ready = 1'b0;
    #1;
    check_eq("rw_gated", freeze_all, 0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rw_idle_frz", freeze_all, 1);
    tick();
    mem_req = 1'b0;
    #1;
    check_eq("rw_wait_frz", freeze_all, 1);
    sram_ready = 1'b1;
    tick();
    sram_ready = 1'b0;
    #1;
    check_eq("rw_back_idle", freeze_all, 0);

    // Saturation of the stall counter
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    check_eq("sat_start", stall_count, 0);
    set_load_use();
    for (int k = 1; k <= (1 << CW) + 2; k++) begin
      tick();
      check_eq($sformatf("sat_%0d", k), stall_count, (k > 15) ? 15 : k);
    end
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_clr", stall_count, 0);
    check_eq("async_stall", hazard_stall, 0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 255: maximum consecutive memory-wait cycles before a timeout error.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 fwd_en  in  1  forwarding enabled (processor mode).
REQ-006 id_valid  in  1  ID stage holds a valid instruction.
REQ-007 id_src1, id_src2  in  4 each  ID source register numbers.
REQ-008 id_two_src  in  1  id_src2 is a real operand.
REQ-009 exe_dest  in  4  EXE destination; exe_wb_en  in  1  EXE writes back; exe_mem_r_en  in  1  EXE is a load.
REQ-010 mem_dest  in  4  MEM destination; mem_wb_en  in  1  MEM writes back.
REQ-011 mem_req  in  1  MEM stage is issuing a data-memory access.
REQ-012 sram_ready  in  1  memory access completes this cycle.
REQ-013 branch_taken  in  1  EXE resolved a taken branch.
REQ-014 hazard_stall  out  1  hold PC and IF/ID, insert bubble into ID/EXE.
REQ-015 freeze_all  out  1  hold every pipeline register.
REQ-016 flush  out  1  clear IF/ID and ID/EXE.
REQ-017 mem_timeout  out  1  sticky memory-timeout error.
REQ-018 stall_count  out  CNT_W  saturating count of hazard_stall cycles.

Function
REQ-019 src2 match SHALL count only when id_two_src=1; all hazard checks SHALL be gated by id_valid.
REQ-020 With fwd_en=1, raw hazard = exe_wb_en & exe_mem_r_en & exe_dest matches a used source.
REQ-021 With fwd_en=0, raw hazard = (exe_wb_en & exe_dest match) | (mem_wb_en & mem_dest match).
REQ-022 Memory FSM states: IDLE, WAIT, ERROR; encoded in a registered state variable.
REQ-023 IDLE -> WAIT when mem_req=1 and sram_ready=0; otherwise stay IDLE.
REQ-024 WAIT -> IDLE when sram_ready=1; WAIT -> ERROR when wait counter reaches WAIT_TIMEOUT with sram_ready=0.
REQ-025 Wait counter SHALL clear in IDLE and increment by 1 each WAIT cycle with sram_ready=0.
REQ-026 ERROR SHALL be terminal until reset; mem_timeout=1 in ERROR, 0 otherwise.
REQ-027 freeze_all (combinational) = (IDLE & mem_req & ~sram_ready) | (WAIT & ~sram_ready) | ERROR.
REQ-028 flush = branch_taken & ~freeze_all; a branch during a freeze is deferred to the first unfrozen cycle.
REQ-029 hazard_stall = raw hazard & ~flush & ~freeze_all (flush and freeze take priority).
REQ-030 hazard_stall, flush, freeze_all SHALL be combinational: asserted in the same cycle as their cause, no added latency.
REQ-031 stall_count SHALL increment by 1 on each clock edge with hazard_stall=1 and saturate at all-ones.
REQ-032 Register numbers 0..15 are all ordinary; no register is exempt from matching.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, wait counter=0, stall_count=0, mem_timeout=0, independent of clk.
REQ-034 During reset, hazard_stall, flush and freeze_all SHALL be 0 regardless of inputs.
REQ-035 Reset released mid-wait SHALL restart in IDLE; an outstanding access re-enters WAIT on the next cycle if still not ready.

Verification
REQ-036 fwd_en=1, exe load dest=3, id_src1=3, id_valid=1 -> hazard_stall=1 same cycle; stall_count 0 -> 1 after the edge.
REQ-037 fwd_en=1, exe non-load dest=3 writing back, id_src1=3 -> hazard_stall=0; with fwd_en=0 -> hazard_stall=1; id_src2=3 with id_two_src=0 -> 0.
REQ-038 mem_req=1, sram_ready=0 for 3 cycles then 1 -> freeze_all=1 for 3 cycles, 0 on the 4th, state back to IDLE.
REQ-039 WAIT_TIMEOUT=4, sram_ready held 0 -> ERROR reached, mem_timeout=1 and freeze_all=1 sticky until rst=0.
REQ-040 branch_taken=1 with load-use hazard present -> flush=1, hazard_stall=0; branch_taken=1 during freeze -> flush=0 until freeze_all drops.
REQ-041 Hold hazard for 2^CNT_W+2 cycles -> stall_count saturates at all-ones; async rst=0 mid-cycle -> stall_count=0 immediately.
